// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared FSM encoding and K=3 code constants for the Viterbi frame controller.
package viterbi_pkg;
    localparam int CODE_K = 3;
    localparam int NUM_STATES = 4;
    localparam int PM_W = 2;
    localparam int TAIL_LEN_DEF = CODE_K - 1;
    typedef enum logic [2:0] {IDLE, CLEAR, DATA, TAIL, DRAIN, DONE} state_t;
endpackage

// File: rtl/vit_tag_delay.sv
// vit_tag_delay: DEPTH-stage 1-bit shift register aligning step tags with datapath decisions.
module vit_tag_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    assign q = sr[DEPTH-1];
    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sr <= '0;
            else sr <= d;
    end else begin : g_shift
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sr <= '0;
            else sr <= {sr[DEPTH-2:0], d};
    end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: sequences one frame of data plus zero-tail steps into a Viterbi
// datapath and forwards only the data-aligned decisions as decoded bits.
module viterbi_frame_ctrl import viterbi_pkg::*; #(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = TAIL_LEN_DEF,
    parameter int DEC_LAT   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_sym_valid,
    input  logic [1:0] i_sym,
    output logic       o_sym_ready,
    output logic       o_dp_clear,
    output logic       o_dp_valid,
    output logic [1:0] o_dp_sym,
    input  logic       i_decision,
    output logic       o_bit_valid,
    output logic       o_bit,
    output logic       o_busy,
    output logic       o_done
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TAIL_LEN + 1);
    localparam logic [CW-1:0] LAST_IN   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] ALL_OUT   = CW'(FRAME_LEN);
    localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);

    state_t        state, state_nx;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [TW-1:0] tail_cnt;
    logic          hs, dp_data, tag_q;

    assign o_sym_ready = state == DATA;
    assign hs          = o_sym_ready & i_sym_valid;
    assign o_dp_clear  = state == CLEAR;
    assign o_busy      = state != IDLE;
    assign o_done      = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_start ? CLEAR : IDLE;
            CLEAR:   state_nx = DATA;
            DATA:    state_nx = (hs && in_cnt == LAST_IN) ? TAIL : DATA;
            TAIL:    state_nx = (tail_cnt == LAST_TAIL) ? DRAIN : TAIL;
            DRAIN:   state_nx = (out_cnt == ALL_OUT) ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters sit at zero throughout IDLE, so every frame enters CLEAR with fresh counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            tail_cnt    <= '0;
            o_dp_valid  <= 1'b0;
            o_dp_sym    <= 2'b00;
            dp_data     <= 1'b0;
            o_bit_valid <= 1'b0;
            o_bit       <= 1'b0;
        end else begin
            state       <= state_nx;
            in_cnt      <= (state == IDLE) ? '0 : in_cnt + CW'(hs);
            out_cnt     <= (state == IDLE) ? '0 : out_cnt + CW'(o_bit_valid);
            tail_cnt    <= (state == TAIL) ? tail_cnt + TW'(1) : '0;
            o_dp_valid  <= hs | (state == TAIL);
            o_dp_sym    <= hs ? i_sym : 2'b00;
            dp_data     <= hs;
            o_bit_valid <= tag_q;
            o_bit       <= tag_q & i_decision;
        end
    end

    vit_tag_delay #(.DEPTH(DEC_LAT)) u_tag (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (o_dp_valid & dp_data),
        .q     (tag_q)
    );
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: randomized frames on three configurations, checked cycle by cycle
// against an expected timeline derived from handshake positions and decision latency.
module tb_viterbi_frame_ctrl;
    localparam int NU   = 3;
    localparam int NMAX = 256;
    localparam int T    = 2;

    function automatic int len_of(input int u);
        return (u == 2) ? 1 : 4;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 1) ? 3 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NU-1:0] start = '0, sv = '0, dec = '0;
    logic [1:0]    sym [NU];
    logic [NU-1:0] rdy, clr, dpv, bv, bt, busy, done;
    logic [1:0]    dsym [NU];
    int            pass = 0, total = 0;

    bit            st [NMAX], vl [NMAX], dc [NMAX];
    logic [1:0]    sy [NMAX], e_sym [NMAX];
    bit            e_rdy [NMAX], e_clr [NMAX], e_dpv [NMAX], e_bv [NMAX], e_bt [NMAX];
    bit            e_busy [NMAX], e_done [NMAX];
    int            hsc [16];
    int            nc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        viterbi_frame_ctrl #(.FRAME_LEN(len_of(g)), .TAIL_LEN(T), .DEC_LAT(lat_of(g))) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start[g]),
            .i_sym_valid (sv[g]),
            .i_sym       (sym[g]),
            .o_sym_ready (rdy[g]),
            .o_dp_clear  (clr[g]),
            .o_dp_valid  (dpv[g]),
            .o_dp_sym    (dsym[g]),
            .i_decision  (dec[g]),
            .o_bit_valid (bv[g]),
            .o_bit       (bt[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g])
        );
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    endtask

    // Cycle n is the interval after the n-th rising edge of the frame; start is driven in cycle 0.
    // mode: 0 valid always high, 1 valid every other cycle, 2 random valid.
    task automatic plan(input int u, input int mode, input bit pat, input bit tailhit, input bit xs);
        int cnt, last, lastbit, drain, dn, n, l, d;
        logic [1:0] pv [4];
        pv[0] = 2'b00; pv[1] = 2'b11; pv[2] = 2'b10; pv[3] = 2'b01;
        l = len_of(u);
        d = lat_of(u);
        for (int i = 0; i < NMAX; i++) begin
            st[i] = 1'b0;
            vl[i] = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : 1'($urandom);
            sy[i] = 2'($urandom);
            dc[i] = tailhit ? 1'b0 : 1'($urandom);
            e_rdy[i] = 0; e_clr[i] = 0; e_dpv[i] = 0; e_bv[i] = 0; e_bt[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_sym[i] = 2'b00;
        end
        st[0] = 1'b1;
        e_clr[1] = 1'b1;
        cnt = 0;
        last = 0;
        n = 2;
        while (cnt < l) begin
            if (n > 100) vl[n] = 1'b1;
            e_rdy[n] = 1'b1;
            if (vl[n]) begin
                if (pat) sy[n] = pv[cnt];
                e_dpv[n+1] = 1'b1;
                e_sym[n+1] = sy[n];
                hsc[cnt] = n;
                cnt++;
                last = n;
            end
            n++;
        end
        for (int t = 0; t < T; t++) begin
            e_dpv[last+2+t] = 1'b1;
            if (tailhit) dc[last+2+t+d] = 1'b1;
        end
        for (int k = 0; k < l; k++) begin
            e_bv[hsc[k]+2+d] = 1'b1;
            e_bt[hsc[k]+2+d] = dc[hsc[k]+1+d];
        end
        lastbit = hsc[l-1] + 2 + d;
        drain = last + T + 1;
        dn = ((lastbit + 1 > drain) ? lastbit + 1 : drain) + 1;
        for (int i = 1; i <= dn; i++) e_busy[i] = 1'b1;
        e_done[dn] = 1'b1;
        if (xs) for (int k = 0; k < 3; k++) st[$urandom_range(1, dn)] = 1'b1;
        nc = dn + 3;
    endtask

    task automatic run(input int u, input int cut);
        int nb, nd;
        nb = 0;
        nd = 0;
        for (int n = 0; n < nc; n++) begin
            @(posedge clk);
            #1;
            start = '0; sv = '0; dec = '0;
            start[u] = st[n]; sv[u] = vl[n]; dec[u] = dc[n]; sym[u] = sy[n];
            @(negedge clk);
            check("sym_ready", int'(rdy[u]), int'(e_rdy[n]));
            check("dp_clear", int'(clr[u]), int'(e_clr[n]));
            check("dp_valid", int'(dpv[u]), int'(e_dpv[n]));
            check("dp_sym", int'(dsym[u]), int'(e_sym[n]));
            check("bit_valid", int'(bv[u]), int'(e_bv[n]));
            check("bit", int'(bt[u]), int'(e_bt[n]));
            check("busy", int'(busy[u]), int'(e_busy[n]));
            check("done", int'(done[u]), int'(e_done[n]));
            nb += int'(bv[u]);
            nd += int'(done[u]);
            if (n == cut) begin
                rst_n = 1'b0;
                #1;
                check("reset_outputs", int'({rdy, clr, dpv, bv, bt, busy, done, dsym[0], dsym[1], dsym[2]}), 0);
                start = '0; sv = '0; dec = '0;
                return;
            end
        end
        check("bit_count", nb, len_of(u));
        check("done_count", nd, 1);
        start = '0; sv = '0; dec = '0;
    endtask

    initial begin
        for (int i = 0; i < NU; i++) sym[i] = 2'b00;
        #1;
        check("reset_outputs", int'({rdy, clr, dpv, bv, bt, busy, done, dsym[0], dsym[1], dsym[2]}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("idle_busy", int'(busy), 0);
        plan(0, 0, 1, 0, 0); run(0, -1);
        plan(0, 1, 1, 0, 0); run(0, -1);
        plan(0, 2, 0, 0, 1); run(0, -1);
        plan(0, 0, 1, 0, 0); run(0, 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        plan(0, 0, 1, 0, 0); run(0, -1);
        plan(1, 0, 1, 1, 0); run(1, -1);
        plan(1, 2, 0, 1, 1); run(1, -1);
        plan(1, 1, 1, 0, 0); run(1, -1);
        plan(2, 0, 0, 0, 0); run(2, -1);
        plan(2, 1, 0, 0, 1); run(2, -1);
        for (int k = 0; k < 9; k++) begin
            plan(k % NU, 2, 0, 0, 1);
            run(k % NU, -1);
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 16, number of coded symbol pairs (information bits) per frame, legal range 1..1023.
REQ-002 Parameter TAIL_LEN, default 2, number of zero flush symbols appended per frame (K-1 for K=3).
REQ-003 Parameter DEC_LAT, default 1, cycles from a datapath valid cycle to the matching decision on i_decision, legal range 1..32.
REQ-004 i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start  in  1  one-cycle pulse that begins a frame.
REQ-007 i_sym_valid  in  1  input symbol pair present.
REQ-008 i_sym  in  2  received coded symbol pair.
REQ-009 o_sym_ready  out  1  controller accepts i_sym this cycle.
REQ-010 o_dp_clear  out  1  clear path metrics / survivor memory of BMU/PMU/SPMU.
REQ-011 o_dp_valid  out  1  drives i_valid of the decoder datapath.
REQ-012 o_dp_sym  out  2  symbol pair presented to the datapath.
REQ-013 i_decision  in  1  decision bit from the survivor path memory unit.
REQ-014 o_bit_valid  out  1  o_bit carries one decoded information bit.
REQ-015 o_bit  out  1  decoded bit.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done  out  1  one-cycle pulse when the last information bit has been output.

Function
REQ-018 FSM states: IDLE, CLEAR, DATA, TAIL, DRAIN, DONE.
REQ-019 IDLE -> CLEAR on i_start; i_start in any other state is ignored.
REQ-020 CLEAR lasts exactly one cycle with o_dp_clear=1, then DATA.
REQ-021 DATA: o_sym_ready=1; each cycle with i_sym_valid&o_sym_ready is one handshake; o_sym_ready=0 in all other states.
REQ-022 Each handshake registers i_sym to o_dp_sym and sets o_dp_valid=1 the next cycle; cycles without a handshake give o_dp_valid=0 (stall, no datapath step).
REQ-023 After the FRAME_LEN-th handshake, DATA -> TAIL; no further symbols are accepted.
REQ-024 TAIL: TAIL_LEN consecutive cycles of o_dp_valid=1 with o_dp_sym=2'b00, then DRAIN.
REQ-025 A tag delay line DEC_LAT deep carries, per cycle, o_dp_valid & (symbol is a data symbol, not tail).
REQ-026 When the delay line output is 1, i_decision is registered: o_bit_valid=1 and o_bit=i_decision on the next cycle; tail decisions never produce o_bit_valid.
REQ-027 An output bit counter of width $clog2(FRAME_LEN+1) counts o_bit_valid; DRAIN -> DONE when it reaches FRAME_LEN.
REQ-028 DONE lasts one cycle with o_done=1, then IDLE; exactly FRAME_LEN bits are output per frame, in input order.
REQ-029 Input and output counters are cleared on entry to CLEAR; no wrap-around occurs within a frame.
REQ-030 FRAME_LEN=1 is legal: one handshake, then TAIL.
REQ-031 i_sym_valid held high across DATA exit is not accepted in TAIL, DRAIN, DONE or IDLE.

Reset
REQ-032 i_rst_n low at any time, including mid-frame, forces IDLE, clears counters and the tag delay line, and drives all outputs to 0 (o_dp_sym=2'b00).
REQ-033 After release, the first i_start is honoured no earlier than the first rising edge with i_rst_n high; a partially decoded frame is discarded.

Structure
REQ-034 Shared package viterbi_pkg holds the FSM state enum, CODE_K=3, NUM_STATES=4, PM_W=2 and the default TAIL_LEN.
REQ-035 One sub-module, vit_tag_delay (parameter DEPTH, 1-bit shift register with async active-low reset), implements the tag delay line.

Verification
REQ-036 FRAME_LEN=4, DEC_LAT=1; i_sym_valid held high, symbols 00,11,10,01 -> o_dp_clear for 1 cycle, o_dp_valid high 6 consecutive cycles (4 data, 2 tail of 00), 4 o_bit_valid pulses equal to i_decision, o_done exactly once.
REQ-037 Same frame with i_sym_valid low every other cycle -> o_dp_valid shows matching gaps, still 4 data plus 2 tail steps, 4 bits out.
REQ-038 i_start pulsed again during DATA and DRAIN -> no effect; o_busy stays high, counts unchanged.
REQ-039 i_rst_n driven low after 2 handshakes -> all outputs 0 immediately; a new i_start then runs a full 4-bit frame correctly.
REQ-040 DEC_LAT=3, i_decision forced to 1 only on tail-aligned cycles -> o_bit never 1 and o_bit_valid count equals 4.
REQ-041 FRAME_LEN=1 -> one handshake, 2 tail steps, one bit, o_done, return to IDLE.
